// File: rtl/seg7_pkg.sv
// Shared constants for the seven-segment scan driver.
// Segment table is active-high; bit0..6 = a..g, bit7 = dp.
package seg7_pkg;

  localparam int SEG_A  = 0;
  localparam int SEG_B  = 1;
  localparam int SEG_C  = 2;
  localparam int SEG_D  = 3;
  localparam int SEG_E  = 4;
  localparam int SEG_F  = 5;
  localparam int SEG_G  = 6;
  localparam int SEG_DP = 7;

  localparam logic [7:0] SEG_OFF = 8'h00;

  // Entry 15 first: packed index n gives the pattern for hex digit n.
  localparam logic [15:0][6:0] HEX_TBL = {
    7'h71, 7'h79, 7'h5E, 7'h39,
    7'h7C, 7'h77, 7'h6F, 7'h7F,
    7'h07, 7'h7D, 7'h6D, 7'h66,
    7'h4F, 7'h5B, 7'h06, 7'h3F
  };

  function automatic logic [6:0] hex_seg(input logic [3:0] nib);
    return HEX_TBL[nib];
  endfunction

endpackage

// File: rtl/seg7_hex_decode.sv
// Nibble + dp + blank to an active-high segment byte.
// Purely combinational; polarity is applied by the caller.
import seg7_pkg::*;

module seg7_hex_decode (
  input  logic [3:0] nib,
  input  logic       dp,
  input  logic       blank,
  output logic [7:0] seg
);

  always_comb begin
    seg = SEG_OFF;
    if (!blank) begin
      seg[SEG_G:SEG_A] = hex_seg(nib);
      seg[SEG_DP]      = dp;
    end
  end

endmodule

// File: rtl/seg7_scan_driver.sv
// Time-multiplexed seven-segment scanner with tear-free
// shadow update, leading-zero suppression and dead time.
import seg7_pkg::*;

module seg7_scan_driver #(
  parameter int DIGITS      = 4,
  parameter int SCAN_DIV    = 50000,
  parameter int BLANK_CYC   = 500,
  parameter int SEG_ACT_LOW = 0,
  parameter int SEL_ACT_LOW = 1,
  parameter int LZ_EN       = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  load,
  input  logic [4*DIGITS-1:0]   data_in,
  input  logic [DIGITS-1:0]     dp_in,
  input  logic [DIGITS-1:0]     blank_in,
  input  logic                  lz_on,
  output logic [7:0]            seg,
  output logic [DIGITS-1:0]     sel,
  output logic                  frame_start,
  output logic                  busy
);

  localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam int CW = $clog2(SCAN_DIV);
  localparam int DW = 4 * DIGITS;

  localparam logic [7:0] SEG_IDLE =
    (SEG_ACT_LOW != 0) ? ~SEG_OFF : SEG_OFF;
  localparam logic [DIGITS-1:0] SEL_IDLE =
    (SEL_ACT_LOW != 0) ? {DIGITS{1'b1}} : {DIGITS{1'b0}};

  typedef struct packed {
    logic [DW-1:0]     data;
    logic [DIGITS-1:0] dp;
    logic [DIGITS-1:0] blank;
    logic              lz;
  } disp_t;

  logic [CW-1:0]     div_cnt_q, div_cnt_d;
  logic [IW-1:0]     dig_idx_q, dig_idx_d;
  disp_t             stg_q, stg_d;
  disp_t             shd_q, shd_d;
  logic              pend_q, pend_d;
  logic [7:0]        seg_q, seg_d;
  logic [DIGITS-1:0] sel_q, sel_d;
  logic              fs_q, fs_d;

  disp_t             in_w;
  logic              last_div;
  logic              frame_end;
  logic [DIGITS-1:0] supp;
  logic              run;
  logic [3:0]        cur_nib;
  logic              cur_dp;
  logic              cur_dark;
  logic [DIGITS-1:0] sel_hot;
  logic [7:0]        dec;

  assign in_w      = '{data: data_in, dp: dp_in,
                       blank: blank_in, lz: lz_on};
  assign last_div  = (div_cnt_q == CW'(SCAN_DIV - 1));
  assign frame_end = last_div && (dig_idx_q == IW'(DIGITS - 1));

  // Walk from the top digit down; a nonzero nibble or a dp ends the run.
  always_comb begin
    supp = '0;
    run  = 1'b1;
    for (int i = DIGITS - 1; i >= 0; i--) begin
      run = run && (shd_q.data[4*i +: 4] == 4'd0) && !shd_q.dp[i];
      supp[i] = run && shd_q.lz && (LZ_EN != 0) && (i != 0);
    end
  end

  always_comb begin
    cur_nib  = 4'd0;
    cur_dp   = 1'b0;
    cur_dark = 1'b0;
    sel_hot  = '0;
    for (int i = 0; i < DIGITS; i++) begin
      if (dig_idx_q == IW'(i)) begin
        cur_nib    = shd_q.data[4*i +: 4];
        cur_dp     = shd_q.dp[i];
        cur_dark   = shd_q.blank[i] || supp[i];
        sel_hot[i] = 1'b1;
      end
    end
  end

  seg7_hex_decode u_dec (
    .nib   (cur_nib),
    .dp    (cur_dp),
    .blank (cur_dark),
    .seg   (dec)
  );

  always_comb begin
    div_cnt_d = last_div ? '0 : div_cnt_q + CW'(1);
    dig_idx_d = dig_idx_q;
    if (last_div) begin
      dig_idx_d = (dig_idx_q == IW'(DIGITS - 1)) ?
                  '0 : dig_idx_q + IW'(1);
    end

    stg_d  = load ? in_w : stg_q;
    shd_d  = shd_q;
    pend_d = pend_q;
    // A load on the frame-end cycle bypasses staging into shadow.
    if (frame_end) begin
      pend_d = 1'b0;
      if (load)        shd_d = in_w;
      else if (pend_q) shd_d = stg_q;
    end else if (load) begin
      pend_d = 1'b1;
    end

    seg_d = SEG_IDLE;
    sel_d = SEL_IDLE;
    if (div_cnt_q >= CW'(BLANK_CYC)) begin
      seg_d = (SEG_ACT_LOW != 0) ? ~dec : dec;
      sel_d = (SEL_ACT_LOW != 0) ? ~sel_hot : sel_hot;
    end
    fs_d = (div_cnt_q == '0) && (dig_idx_q == '0);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      div_cnt_q <= '0;
      dig_idx_q <= '0;
      stg_q     <= '0;
      shd_q     <= '0;
      pend_q    <= 1'b0;
      seg_q     <= SEG_IDLE;
      sel_q     <= SEL_IDLE;
      fs_q      <= 1'b0;
    end else begin
      div_cnt_q <= div_cnt_d;
      dig_idx_q <= dig_idx_d;
      stg_q     <= stg_d;
      shd_q     <= shd_d;
      pend_q    <= pend_d;
      seg_q     <= seg_d;
      sel_q     <= sel_d;
      fs_q      <= fs_d;
    end
  end

  assign seg         = seg_q;
  assign sel         = sel_q;
  assign frame_start = fs_q;
  assign busy        = pend_q;

endmodule

// File: tb/tb_seg7_scan_driver.sv
// Scoreboard bench: a frame-level model pushes expected outputs,
// a negedge monitor pops and compares against two DUT polarities.
module tb_seg7_scan_driver;

  localparam int SD  = 8;
  localparam int BC  = 2;
  localparam int ND  = 4;
  localparam int FRM = SD * ND;

  typedef struct {
    logic [15:0] data;
    logic [3:0]  dp;
    logic [3:0]  blank;
    logic        lz;
  } disp_t;

  typedef struct {
    logic [7:0] seg_a;
    logic [3:0] sel_a;
    logic [7:0] seg_b;
    logic [3:0] sel_b;
    logic       fs;
    logic       busy;
  } exp_t;

  bit [6:0] hexref [16] = '{
    7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
    7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71
  };

  logic        clk = 1'b0;
  logic        rst;
  logic        load;
  logic [15:0] data_in;
  logic [3:0]  dp_in;
  logic [3:0]  blank_in;
  logic        lz_on;
  logic [7:0]  seg_a, seg_b;
  logic [3:0]  sel_a, sel_b;
  logic        fs_a, fs_b, busy_a, busy_b;

  int    total = 0;
  int    bad   = 0;
  int    cnt   = 0;
  bit    seen  = 0;
  bit    pend  = 0;
  disp_t shd, stg;
  exp_t  expq[$];

  always #5 clk = ~clk;

  seg7_scan_driver #(
    .DIGITS(ND), .SCAN_DIV(SD), .BLANK_CYC(BC),
    .SEG_ACT_LOW(0), .SEL_ACT_LOW(1), .LZ_EN(1)
  ) dut_a (
    .clk(clk), .rst(rst), .load(load), .data_in(data_in),
    .dp_in(dp_in), .blank_in(blank_in), .lz_on(lz_on),
    .seg(seg_a), .sel(sel_a), .frame_start(fs_a), .busy(busy_a)
  );

  seg7_scan_driver #(
    .DIGITS(ND), .SCAN_DIV(SD), .BLANK_CYC(BC),
    .SEG_ACT_LOW(1), .SEL_ACT_LOW(0), .LZ_EN(1)
  ) dut_b (
    .clk(clk), .rst(rst), .load(load), .data_in(data_in),
    .dp_in(dp_in), .blank_in(blank_in), .lz_on(lz_on),
    .seg(seg_b), .sel(sel_b), .frame_start(fs_b), .busy(busy_b)
  );

  function automatic logic [7:0] ref_seg(disp_t d, int k);
    logic [3:0] nib;
    bit         dark;
    nib  = 4'((d.data >> (4 * k)) & 16'hF);
    dark = d.blank[k] ||
           (d.lz && k > 0 && (d.data >> (4 * k)) == 0 &&
            (d.dp >> k) == 0);
    if (dark) return 8'h00;
    return {d.dp[k], hexref[nib]};
  endfunction

  // Reference: cycle count since reset gives slot and offset directly.
  always @(posedge clk) begin
    exp_t e;
    int   off, slot, fpos;
    disp_t nw;
    nw = '{data: data_in, dp: dp_in, blank: blank_in, lz: lz_on};
    if (rst) begin
      cnt = 0;
      pend = 0;
      shd = '{16'h0, 4'h0, 4'h0, 1'b0};
      stg = shd;
      e = '{seg_a: 8'h00, sel_a: 4'hF, seg_b: 8'hFF,
            sel_b: 4'h0, fs: 1'b0, busy: 1'b0};
    end else begin
      off  = cnt % SD;
      slot = (cnt / SD) % ND;
      fpos = cnt % FRM;
      if (off < BC) begin
        e.seg_a = 8'h00; e.sel_a = 4'hF;
        e.seg_b = 8'hFF; e.sel_b = 4'h0;
      end else begin
        e.seg_a = ref_seg(shd, slot);
        e.seg_b = ~e.seg_a;
        e.sel_b = 4'(1 << slot);
        e.sel_a = ~e.sel_b;
      end
      e.fs = (fpos == 0);
      if (load) stg = nw;
      if (fpos == FRM - 1) begin
        if (load) shd = nw;
        else if (pend) shd = stg;
        pend = 0;
      end else if (load) begin
        pend = 1;
      end
      e.busy = pend;
      cnt++;
    end
    expq.push_back(e);
    seen = 1;
  end

  task automatic check(string name, logic [7:0] act, logic [7:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s act=%h req=%h t=%0t", name, act, req, $time);
    end
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (expq.size() > 0) begin
      e = expq.pop_front();
      check("seg_a", seg_a, e.seg_a);
      check("sel_a", 8'(sel_a), 8'(e.sel_a));
      check("seg_b", seg_b, e.seg_b);
      check("sel_b", 8'(sel_b), 8'(e.sel_b));
      check("frame_start_a", 8'(fs_a), 8'(e.fs));
      check("frame_start_b", 8'(fs_b), 8'(e.fs));
      check("busy_a", 8'(busy_a), 8'(e.busy));
      check("busy_b", 8'(busy_b), 8'(e.busy));
    end else if (seen) begin
      total++;
      bad++;
      $display("FAIL scoreboard act=empty req=entry t=%0t", $time);
    end
  end

  task automatic tick(int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic put(logic [15:0] d, logic [3:0] p,
                     logic [3:0] b, logic z);
    load = 1'b1; data_in = d; dp_in = p; blank_in = b; lz_on = z;
    @(negedge clk);
    load = 1'b0;
  endtask

  task automatic do_load(logic [15:0] d, logic [3:0] p,
                         logic [3:0] b, logic z);
    @(negedge clk);
    put(d, p, b, z);
  endtask

  // Aligns so that the next posedge is the frame-end cycle.
  task automatic to_frame_end();
    int k;
    for (k = 0; k < 2 * FRM; k++) begin
      if (cnt % FRM == FRM - 1) break;
      @(negedge clk);
    end
    if (k == 2 * FRM) begin
      total++;
      bad++;
      $display("FAIL frame_end_wait act=timeout req=aligned");
    end
  endtask

  initial begin
    logic [15:0] d;
    rst = 1'b1; load = 1'b0; data_in = '0;
    dp_in = '0; blank_in = '0; lz_on = 1'b0;
    tick(3);
    rst = 1'b0;
    tick(13);
    rst = 1'b1;
    tick(3);
    rst = 1'b0;
    tick(2 * FRM);

    do_load(16'h1A3F, 4'b0100, 4'b0000, 1'b0);
    tick(2 * FRM + 4);
    do_load(16'h0050, 4'b0000, 4'b0000, 1'b1);
    tick(2 * FRM);
    do_load(16'h0000, 4'b0000, 4'b0000, 1'b1);
    tick(2 * FRM);
    do_load(16'h0500, 4'b0010, 4'b1000, 1'b1);
    tick(2 * FRM);

    to_frame_end();
    tick(3);
    put(16'h1111, 4'h0, 4'h0, 1'b0);
    tick(5);
    put(16'h2222, 4'h0, 4'h0, 1'b0);
    tick(2 * FRM);

    to_frame_end();
    put(16'h8888, 4'h0, 4'h0, 1'b0);
    tick(2 * FRM);

    do_load(16'h4321, 4'h0, 4'h0, 1'b0);
    tick(FRM / 2);
    rst = 1'b1;
    tick(2);
    rst = 1'b0;
    tick(FRM + 3);

    for (int i = 0; i < 40; i++) begin
      d = 16'($urandom) >> (4 * $urandom_range(0, 4));
      if ($urandom_range(0, 5) == 0) begin
        to_frame_end();
        put(d, 4'($urandom_range(0, 15) & $urandom_range(0, 15)),
            4'($urandom_range(0, 3) == 0 ? $urandom_range(0, 15) : 0),
            1'($urandom));
      end else begin
        do_load(d,
                4'($urandom_range(0, 15) & $urandom_range(0, 15)),
                4'($urandom_range(0, 3) == 0 ? $urandom_range(0, 15) : 0),
                1'($urandom));
      end
      tick($urandom_range(0, 50));
      if ($urandom_range(0, 12) == 0) begin
        rst = 1'b1;
        tick($urandom_range(1, 3));
        rst = 1'b0;
      end
    end
    tick(2 * FRM);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
